qea_run_sequencer: RTL and testbench

QEA_RUN_SEQUENCER -- requirements
Module: qea_run_sequencer

---
 rtl/qea_run_sequencer.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_qea_run_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qea_run_sequencer.sv
// Job sequencer for the quantum-emulation accelerator: loads gate contexts and the
// state vector, starts the engine, times the run and streams the final state back out.
module qea_run_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int CYC_WIDTH               = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_run,
  input  logic                                 i_abort,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  input  logic                                 i_ctx_valid,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_ctx_ready,
  input  logic                                 i_sv_valid,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_sv_data,
  output logic                                 o_sv_ready,
  output logic                                 o_rd_valid,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
  input  logic                                 i_rd_ready,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic [PE_NUM-1:0]                    o_state_ena,
  output logic [PE_NUM-1:0]                    o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [CYC_WIDTH-1:0]                 o_exec_cycles
);

  localparam int SVW   = PE_NUM * STATE_DATA_WIDTH;
  localparam int CNT_W = (GATE_CONTEXT_ADDR_WIDTH > STATE_ADDR_WIDTH) ?
                         GATE_CONTEXT_ADDR_WIDTH : STATE_ADDR_WIDTH;
  localparam logic [31:0] LP_QMIN = 32'(PE_NUM_WIDTH);
  localparam logic [31:0] LP_QMAX = 32'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  localparam logic [31:0] LP_NMAX = 32'(2 ** GATE_CONTEXT_ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_CTX   = 3'd1,
    S_LD_STATE = 3'd2,
    S_START    = 3'd3,
    S_RUN      = 3'd4,
    S_RD_ISSUE = 3'd5,
    S_RD_WAIT  = 3'd6,
    S_RD_OUT   = 3'd7
  } state_t;

  state_t                               r_state;
  logic [CNT_W-1:0]                     r_cnt;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_last_ins;
  logic [STATE_ADDR_WIDTH-1:0]          r_last_word;
  logic [MAX_QBIT_WIDTH-1:0]            r_qbit;
  logic                                 r_busy;
  logic                                 r_done;
  logic                                 r_err;
  logic [CYC_WIDTH-1:0]                 r_exec;
  logic                                 r_ctx_ready;
  logic                                 r_sv_ready;
  logic                                 r_rd_valid;
  logic [SVW-1:0]                       r_rd_data;
  logic                                 r_qea_start;
  logic                                 r_ctx_en;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_ctx_addr;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   r_ctx_data;
  logic [PE_NUM-1:0]                    r_state_ena;
  logic [PE_NUM-1:0]                    r_state_wea;
  logic [STATE_ADDR_WIDTH-1:0]          r_state_addra;
  logic [SVW-1:0]                       r_state_dina;

  state_t                               w_state_nx;
  logic [CNT_W-1:0]                     w_cnt_nx;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   w_last_ins_nx;
  logic [STATE_ADDR_WIDTH-1:0]          w_last_word_nx;
  logic [MAX_QBIT_WIDTH-1:0]            w_qbit_nx;
  logic                                 w_done_nx;
  logic                                 w_err_nx;
  logic [CYC_WIDTH-1:0]                 w_exec_nx;
  logic [SVW-1:0]                       w_rd_data_nx;
  logic                                 w_ctx_en_nx;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   w_ctx_addr_nx;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   w_ctx_data_nx;
  logic [PE_NUM-1:0]                    w_state_ena_nx;
  logic [PE_NUM-1:0]                    w_state_wea_nx;
  logic [STATE_ADDR_WIDTH-1:0]          w_state_addra_nx;
  logic [SVW-1:0]                       w_state_dina_nx;
  logic [31:0]                          w_q32;
  logic [31:0]                          w_n32;
  logic                                 w_param_ok;

  assign w_q32      = 32'(i_qbit_num);
  assign w_n32      = 32'(i_ins_num);
  assign w_param_ok = (w_q32 > LP_QMIN) && (w_q32 <= LP_QMAX) &&
                      (w_n32 >= 32'd1) && (w_n32 <= LP_NMAX);

  // Next-state and next-output computation; abort overrides every other request.
  always_comb begin
    w_state_nx       = r_state;
    w_cnt_nx         = r_cnt;
    w_last_ins_nx    = r_last_ins;
    w_last_word_nx   = r_last_word;
    w_qbit_nx        = r_qbit;
    w_done_nx        = 1'b0;
    w_err_nx         = 1'b0;
    w_exec_nx        = r_exec;
    w_rd_data_nx     = r_rd_data;
    w_ctx_en_nx      = 1'b0;
    w_ctx_addr_nx    = r_ctx_addr;
    w_ctx_data_nx    = r_ctx_data;
    w_state_ena_nx   = '0;
    w_state_wea_nx   = '0;
    w_state_addra_nx = r_state_addra;
    w_state_dina_nx  = r_state_dina;
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nx = S_IDLE;
      w_qbit_nx  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run && w_param_ok) begin
            w_state_nx     = S_LD_CTX;
            w_cnt_nx       = '0;
            w_qbit_nx      = i_qbit_num;
            w_last_ins_nx  = GATE_CONTEXT_ADDR_WIDTH'(w_n32 - 32'd1);
            w_last_word_nx = STATE_ADDR_WIDTH'((32'd1 << (w_q32 - LP_QMIN)) - 32'd1);
          end else if (i_run) begin
            w_err_nx = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
        S_LD_CTX: begin
          if (i_ctx_valid) begin
            w_ctx_en_nx   = 1'b1;
            w_ctx_addr_nx = r_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
            w_ctx_data_nx = i_ctx_data;
            if (r_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0] == r_last_ins) begin
              w_state_nx = S_LD_STATE;
              w_cnt_nx   = '0;
            end else begin
              w_cnt_nx = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            w_ctx_en_nx = 1'b0;
          end
        end
        S_LD_STATE: begin
          if (i_sv_valid) begin
            w_state_ena_nx   = '1;
            w_state_wea_nx   = '1;
            w_state_addra_nx = r_cnt[STATE_ADDR_WIDTH-1:0];
            w_state_dina_nx  = i_sv_data;
            if (r_cnt[STATE_ADDR_WIDTH-1:0] == r_last_word) begin
              w_state_nx = S_START;
              w_cnt_nx   = '0;
              w_exec_nx  = '0;
            end else begin
              w_cnt_nx = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            w_state_ena_nx = '0;
          end
        end
        S_START: begin
          w_state_nx = S_RUN;
        end
        S_RUN: begin
          // The completion cycle itself is not counted.
          if (i_qea_complete) begin
            w_state_nx       = S_RD_ISSUE;
            w_cnt_nx         = '0;
            w_state_ena_nx   = '1;
            w_state_addra_nx = '0;
          end else if (r_exec != {CYC_WIDTH{1'b1}}) begin
            w_exec_nx = r_exec + {{(CYC_WIDTH-1){1'b0}}, 1'b1};
          end else begin
            w_exec_nx = r_exec;
          end
        end
        S_RD_ISSUE: begin
          w_state_nx = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          w_state_nx   = S_RD_OUT;
          w_rd_data_nx = i_qea_state_dout;
        end
        S_RD_OUT: begin
          if (i_rd_ready && (r_cnt[STATE_ADDR_WIDTH-1:0] == r_last_word)) begin
            w_state_nx = S_IDLE;
            w_done_nx  = 1'b1;
            w_qbit_nx  = '0;
          end else if (i_rd_ready) begin
            w_state_nx       = S_RD_ISSUE;
            w_cnt_nx         = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            w_state_ena_nx   = '1;
            w_state_addra_nx = w_cnt_nx[STATE_ADDR_WIDTH-1:0];
          end else begin
            w_state_nx = S_RD_OUT;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_qbit_nx  = '0;
        end
      endcase
    end
  end

  // State and registered-output update; the stream readies follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_last_ins    <= '0;
      r_last_word   <= '0;
      r_qbit        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_exec        <= '0;
      r_ctx_ready   <= 1'b0;
      r_sv_ready    <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_qea_start   <= 1'b0;
      r_ctx_en      <= 1'b0;
      r_ctx_addr    <= '0;
      r_ctx_data    <= '0;
      r_state_ena   <= '0;
      r_state_wea   <= '0;
      r_state_addra <= '0;
      r_state_dina  <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_last_ins    <= w_last_ins_nx;
      r_last_word   <= w_last_word_nx;
      r_qbit        <= w_qbit_nx;
      r_busy        <= (w_state_nx != S_IDLE);
      r_done        <= w_done_nx;
      r_err         <= w_err_nx;
      r_exec        <= w_exec_nx;
      r_ctx_ready   <= (w_state_nx == S_LD_CTX);
      r_sv_ready    <= (w_state_nx == S_LD_STATE);
      r_rd_valid    <= (w_state_nx == S_RD_OUT);
      r_rd_data     <= w_rd_data_nx;
      r_qea_start   <= (w_state_nx == S_START);
      r_ctx_en      <= w_ctx_en_nx;
      r_ctx_addr    <= w_ctx_addr_nx;
      r_ctx_data    <= w_ctx_data_nx;
      r_state_ena   <= w_state_ena_nx;
      r_state_wea   <= w_state_wea_nx;
      r_state_addra <= w_state_addra_nx;
      r_state_dina  <= w_state_dina_nx;
    end
  end

  assign o_ctx_ready    = r_ctx_ready;
  assign o_sv_ready     = r_sv_ready;
  assign o_rd_valid     = r_rd_valid;
  assign o_rd_data      = r_rd_data;
  assign o_qea_start    = r_qea_start;
  assign o_qea_qbit_num = r_qbit;
  assign o_ctx_en       = r_ctx_en;
  assign o_ctx_wea      = r_ctx_en;
  assign o_ctx_addr     = r_ctx_addr;
  assign o_ctx_data     = r_ctx_data;
  assign o_state_ena    = r_state_ena;
  assign o_state_wea    = r_state_wea;
  assign o_state_addra  = r_state_addra;
  assign o_state_dina   = r_state_dina;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_exec_cycles  = r_exec;

endmodule

// File: tb/tb_qea_run_sequencer.sv
// Bench for qea_run_sequencer: random job data and stream timing, with a state-RAM
// and engine model, checked against the job rules (addresses, counts, ordering).
module tb_qea_run_sequencer;
  localparam int SVW = 256;

  logic clk = 1'b0;
  logic rst;
  logic i_run, i_abort, i_ctx_valid, i_sv_valid, i_rd_ready, i_qea_complete;
  logic [5:0] i_qbit_num;
  logic [16:0] i_ins_num;
  logic [63:0] i_ctx_data;
  logic [SVW-1:0] i_sv_data;
  logic o_ctx_ready, o_sv_ready, o_rd_valid, o_qea_start, o_ctx_en, o_ctx_wea;
  logic [SVW-1:0] o_rd_data, o_state_dina, ram_dout;
  logic [5:0] o_qea_qbit_num;
  logic [15:0] o_ctx_addr, o_state_addra;
  logic [63:0] o_ctx_data;
  logic [3:0] o_state_ena, o_state_wea;
  logic o_busy, o_done, o_err;
  logic [31:0] o_exec_cycles;

  always #5 clk = ~clk;

  qea_run_sequencer dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_abort(i_abort),
    .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .i_ctx_valid(i_ctx_valid), .i_ctx_data(i_ctx_data), .o_ctx_ready(o_ctx_ready),
    .i_sv_valid(i_sv_valid), .i_sv_data(i_sv_data), .o_sv_ready(o_sv_ready),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
    .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr),
    .o_ctx_data(o_ctx_data), .o_state_ena(o_state_ena), .o_state_wea(o_state_wea),
    .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
    .i_qea_complete(i_qea_complete), .i_qea_state_dout(ram_dout),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_exec_cycles(o_exec_cycles)
  );

  // State RAM model with one cycle of read latency.
  logic [SVW-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (o_state_ena == 4'hF && o_state_wea == 4'hF) mem[o_state_addra] <= o_state_dina;
    else if (o_state_ena == 4'hF && o_state_wea == 4'h0) ram_dout <= mem[o_state_addra];
  end

  // Event logs, sampled mid-cycle.
  logic [15:0] ctx_addr_log[$], sw_addr_log[$];
  logic [63:0] ctx_data_log[$];
  logic [SVW-1:0] sw_data_log[$];
  int start_cnt = 0, done_cnt = 0, err_cnt = 0, rd_issue_cnt = 0, bad_cnt = 0;
  always @(negedge clk) begin
    if (o_ctx_en) begin
      ctx_addr_log.push_back(o_ctx_addr);
      ctx_data_log.push_back(o_ctx_data);
      if (!o_ctx_wea) bad_cnt++;
    end
    if (o_state_ena != 4'h0) begin
      if (o_state_ena != 4'hF) bad_cnt++;
      else if (o_state_wea == 4'hF) begin
        sw_addr_log.push_back(o_state_addra);
        sw_data_log.push_back(o_state_dina);
      end else if (o_state_wea == 4'h0) rd_issue_cnt++;
      else bad_cnt++;
    end
    if (o_qea_start) start_cnt++;
    if (o_done) done_cnt++;
    if (o_err) err_cnt++;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [SVW-1:0] obs, input logic [SVW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit param_ok(input int q, input int n);
    return (q > 2) && (q <= 18) && (n >= 1) && (n <= 65536);
  endfunction

  task automatic launch(input int q, input int n);
    i_run = 1'b1; i_qbit_num = q[5:0]; i_ins_num = n[16:0];
    @(posedge clk); #1;
    i_run = 1'b0;
  endtask

  task automatic send_ctx(input logic [63:0] words[$], input int mode);
    int sent = 0, cyc = 0;
    bit hs, v;
    while (sent < words.size() && cyc < 20000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      i_ctx_valid = v;
      i_ctx_data = v ? words[sent] : {$urandom, $urandom};
      @(negedge clk); hs = i_ctx_valid && o_ctx_ready;
      @(posedge clk); #1;
      if (hs) sent++;
      cyc++;
    end
    i_ctx_valid = 1'b0;
    chk("ctx_stream_accepted", sent, words.size());
  endtask

  task automatic send_sv(input logic [SVW-1:0] words[$], input int mode);
    int sent = 0, cyc = 0;
    bit hs, v;
    while (sent < words.size() && cyc < 40000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      i_sv_valid = v;
      i_sv_data = v ? words[sent] : {8{$urandom}};
      @(negedge clk); hs = i_sv_valid && o_sv_ready;
      @(posedge clk); #1;
      if (hs) sent++;
      cyc++;
    end
    i_sv_valid = 1'b0;
    chk("sv_stream_accepted", sent, words.size());
  endtask

  // Engine model: completes after run_len uncounted-free RUN cycles.
  task automatic engine(input int run_len);
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk); seen = o_qea_start;
    end
    chk("start_seen", seen, 1'b1);
    @(posedge clk);
    repeat (run_len) @(posedge clk);
    #1 i_qea_complete = 1'b1;
    @(posedge clk); #1 i_qea_complete = 1'b0;
    chk($sformatf("exec_cycles_run%0d", run_len), o_exec_cycles, run_len);
  endtask

  // Collect readout words; mode 3 holds ready low for 5 cycles on the first word.
  task automatic drain(input int w, input int mode, output logic [SVW-1:0] got[$]);
    int cyc = 0, ri;
    bit held = 1'b0;
    logic [SVW-1:0] d0;
    got = {};
    while (got.size() < w && cyc < w * 20 + 200) begin
      i_rd_ready = (mode == 3 && !held) ? 1'b0 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (o_rd_valid && i_rd_ready) got.push_back(o_rd_data);
      if (mode == 3 && !held && o_rd_valid) begin
        d0 = o_rd_data; ri = rd_issue_cnt;
        repeat (4) begin
          @(negedge clk);
          chk("stall_data_stable", o_rd_data, d0);
          chk("stall_valid_held", o_rd_valid, 1'b1);
          chk("stall_no_new_read", rd_issue_cnt, ri);
        end
        held = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_rd_ready = 1'b0;
  endtask

  task automatic run_job(input int q, input int n, input int cm, input int sm, input int rm,
                         input int run_len);
    int w = 1 << (q - 2);
    int cb = ctx_addr_log.size(), sb = sw_addr_log.size();
    int st0 = start_cnt, dn0 = done_cnt, er0 = err_cnt, mism;
    logic [63:0] cw[$];
    logic [SVW-1:0] sw[$], got[$];
    for (int k = 0; k < n; k++) cw.push_back({$urandom, $urandom});
    for (int j = 0; j < w; j++) sw.push_back({8{$urandom}});
    launch(q, n);
    chk("launch_busy", o_busy, 1'b1);
    chk("launch_qbit_num", o_qea_qbit_num, q);
    chk("launch_ctx_ready", o_ctx_ready, 1'b1);
    send_ctx(cw, cm);
    send_sv(sw, sm);
    engine(run_len);
    drain(w, rm, got);
    chk("done_pulse", o_done, 1'b1);
    chk("idle_after_done", o_busy, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", o_done, 1'b0);
    chk("exec_held", o_exec_cycles, run_len);
    chk("ctx_write_count", ctx_addr_log.size() - cb, n);
    mism = 0;
    for (int k = 0; k < n && cb + k < ctx_addr_log.size(); k++)
      if (ctx_addr_log[cb + k] !== 16'(k) || ctx_data_log[cb + k] !== cw[k]) mism++;
    chk("ctx_write_contents", mism, 0);
    chk("ctx_last_addr", ctx_addr_log[ctx_addr_log.size() - 1], n - 1);
    chk("state_write_count", sw_addr_log.size() - sb, w);
    mism = 0;
    for (int j = 0; j < w && sb + j < sw_addr_log.size(); j++)
      if (sw_addr_log[sb + j] !== 16'(j) || sw_data_log[sb + j] !== sw[j]) mism++;
    chk("state_write_contents", mism, 0);
    chk("readout_count", got.size(), w);
    mism = 0;
    for (int j = 0; j < w && j < got.size(); j++) if (got[j] !== sw[j]) mism++;
    chk("readout_order", mism, 0);
    chk("start_pulses", start_cnt - st0, 1);
    chk("done_pulses", done_cnt - dn0, 1);
    chk("no_err", err_cnt - er0, 0);
  endtask

  initial begin
    int qs[8] = '{2, 5, 19, 5, 0, 18, 3, 17};
    int ns[8] = '{5, 0, 3, 65537, 1, 65536, 0, 65536};
    int cb, sb, dn0;
    logic [63:0] cw[$];
    logic [SVW-1:0] sw[$];
    rst = 1'b1; i_run = 1'b0; i_abort = 1'b0; i_ctx_valid = 1'b0; i_sv_valid = 1'b0;
    i_rd_ready = 1'b0; i_qea_complete = 1'b0; i_qbit_num = '0; i_ins_num = '0;
    i_ctx_data = '0; i_sv_data = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_flags", {o_busy, o_done, o_err, o_ctx_ready, o_sv_ready, o_rd_valid, o_qea_start, o_ctx_en}, 0);
    chk("rst_state_en", {o_state_ena, o_state_wea}, 0);
    chk("rst_addr", {o_ctx_addr, o_state_addra, o_qea_qbit_num}, 0);
    chk("rst_exec", o_exec_cycles, 0);
    chk("rst_data", o_rd_data ^ o_state_dina ^ SVW'(o_ctx_data), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Parameter legality, including both edges of each range.
    for (int t = 0; t < 8; t++) begin
      cb = ctx_addr_log.size();
      launch(qs[t], ns[t]);
      chk($sformatf("err_q%0d_n%0d", qs[t], ns[t]), o_err, !param_ok(qs[t], ns[t]));
      chk($sformatf("busy_q%0d_n%0d", qs[t], ns[t]), o_busy, param_ok(qs[t], ns[t]));
      if (param_ok(qs[t], ns[t])) begin
        launch(5, 4);
        chk("run_ignored_while_busy", o_qea_qbit_num, qs[t]);
        i_abort = 1'b1; @(posedge clk); #1 i_abort = 1'b0;
      end else begin
        @(posedge clk); #1;
        chk("err_one_cycle", o_err, 1'b0);
      end
      chk("no_engine_activity", {o_busy, o_ctx_ready, o_state_ena, o_qea_start}, 0);
      chk("no_ctx_writes", ctx_addr_log.size() - cb, 0);
    end

    run_job(15, 701, 0, 0, 0, 1000);
    run_job(5, 9, 1, 1, 1, 7);
    run_job(4, 3, 0, 2, 3, 2);
    run_job(3, 1, 0, 0, 0, 0);
    repeat (4) run_job($urandom_range(3, 7), $urandom_range(1, 16), $urandom_range(0, 2),
                       $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 40));

    // Abort while loading the state vector at word 100.
    dn0 = done_cnt;
    cw = {};
    sw = {};
    for (int k = 0; k < 4; k++) cw.push_back({$urandom, $urandom});
    for (int j = 0; j < 100; j++) sw.push_back({8{$urandom}});
    launch(10, 4);
    send_ctx(cw, 0);
    sb = sw_addr_log.size();
    send_sv(sw, 0);
    i_sv_valid = 1'b1; i_sv_data = {8{$urandom}}; i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0; i_sv_valid = 1'b0;
    chk("abort_enables_off", {o_busy, o_sv_ready, o_ctx_ready, o_ctx_en, o_state_ena, o_rd_valid, o_qea_start}, 0);
    repeat (5) @(posedge clk); #1;
    chk("abort_no_done", done_cnt - dn0, 0);
    chk("abort_write_count", sw_addr_log.size() - sb, 100);
    chk("abort_last_addr", sw_addr_log[sw_addr_log.size() - 1], 99);
    run_job(6, 5, 2, 2, 1, 12);

    // Reset in the middle of a context load.
    cw = {};
    for (int k = 0; k < 3; k++) cw.push_back({$urandom, $urandom});
    launch(4, 8);
    send_ctx(cw, 0);
    cb = ctx_addr_log.size();
    #2 rst = 1'b1;
    #1;
    chk("midjob_rst_idle", {o_busy, o_ctx_ready, o_ctx_en, o_qea_qbit_num}, 0);
    @(posedge clk); #1 rst = 1'b0;
    i_ctx_valid = 1'b1;
    repeat (3) @(posedge clk); #1;
    i_ctx_valid = 1'b0;
    chk("post_rst_no_writes", ctx_addr_log.size() - cb, 0);
    chk("post_rst_idle", {o_busy, o_ctx_ready}, 0);
    run_job(3, 2, 0, 0, 0, 3);

    chk("enable_shapes", bad_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
